pam_modulation: RTL and testbench

Transmit-side PAM modulator for the VLC link. It accepts packed symbol words from an AXI-stream FIFO and emits one frame per burst on the DAC path. Each frame is a pilot ramp of all 2^PAM_ORDER amplitude levels in ascending order, followed by LENGTH_DATA data symbols, then a silent guard gap. The frame format is exactly what the receive-side synchroniser/demodulator chain expects, so threshold training and symbol unpacking match end to end.

---
 rtl/pam_modulation.sv | 242 ++++++++++++++++++++++++
 tb/tb_pam_modulation.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pam_modulation.sv
// PAM transmit modulator: per frame a pilot ramp over all levels, LENGTH_DATA data symbols, then a
// silent guard gap. Define PAM_GRAY_EN to treat data symbols as Gray-coded level indices.
module pam_modulation #(
    parameter int AD_CVER_WIDTH  = 12,
    parameter int LENGTH_DATA    = 1024,
    parameter int PAM_ORDER      = 4,
    parameter int WIDTH_AXI_DATA = 32,
    parameter int GUARD_LEN      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_axi_tvalid,
    output logic                        s_axi_tready,
    input  logic [WIDTH_AXI_DATA-1:0]   s_axi_tdata,
    input  logic [WIDTH_AXI_DATA/8-1:0] s_axi_tkeep,
    input  logic                        s_axi_tlast,
    output logic                        mod_da_valid,
    output logic [AD_CVER_WIDTH-1:0]    mod_da_data,
    output logic                        mod_da_sof,
    output logic                        mod_da_eof,
    output logic                        err_underrun,
    output logic                        err_framing
);

    localparam int Spw   = WIDTH_AXI_DATA / PAM_ORDER;
    localparam int Wpf   = LENGTH_DATA / Spw;
    localparam int NLev  = 1 << PAM_ORDER;
    localparam int CntW  = $clog2(LENGTH_DATA + NLev);
    localparam int SlotW = $clog2(Spw + 1);
    localparam int WordW = $clog2(Wpf + 1);
    localparam int GapW  = $clog2(GUARD_LEN + 1);

    localparam logic [CntW-1:0]  LastPilot = CntW'(NLev - 1);
    localparam logic [CntW-1:0]  LastSym   = CntW'(LENGTH_DATA - 1);
    localparam logic [SlotW-1:0] LastSlot  = SlotW'(Spw - 1);
    localparam logic [WordW-1:0] LastWord  = WordW'(Wpf - 1);
    localparam logic [GapW-1:0]  LastGap   = GapW'(GUARD_LEN - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPilot = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StGap   = 2'd3;

    // Offset-binary to two's complement: invert the index MSB, left-justify in the DAC word.
    function automatic logic [AD_CVER_WIDTH-1:0] level_of(input logic [PAM_ORDER-1:0] k);
        logic [AD_CVER_WIDTH-1:0] r;
        r = '0;
        r[AD_CVER_WIDTH-1 -: PAM_ORDER] = k;
        r[AD_CVER_WIDTH-1] = ~r[AD_CVER_WIDTH-1];
        return r;
    endfunction

`ifdef PAM_GRAY_EN
    function automatic logic [PAM_ORDER-1:0] gray2bin(input logic [PAM_ORDER-1:0] g);
        logic [PAM_ORDER-1:0] b;
        b[PAM_ORDER-1] = g[PAM_ORDER-1];
        for (int i = PAM_ORDER - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`endif

    logic [1:0]                state_q, state_d;
    logic [CntW-1:0]           sym_cnt_q, sym_cnt_d;
    logic [SlotW-1:0]          slot_cnt_q, slot_cnt_d;
    logic [WordW-1:0]          word_cnt_q, word_cnt_d;
    logic [GapW-1:0]           gap_cnt_q, gap_cnt_d;
    logic [WIDTH_AXI_DATA-1:0] hold_q, hold_d;
    logic                      hold_full_q, hold_full_d;
    logic                      hold_last_q, hold_last_d;
    logic [WIDTH_AXI_DATA-1:0] shift_q, shift_d;
    logic                      slot_empty_q, slot_empty_d;
    logic                      valid_q, valid_d;
    logic [AD_CVER_WIDTH-1:0]  data_q, data_d;
    logic                      sof_q, sof_d;
    logic                      eof_q, eof_d;
    logic                      err_underrun_q, err_underrun_d;
    logic                      err_framing_q, err_framing_d;

    logic                      load_shift;
    logic                      hold_unload;
    logic                      accept;
    logic [PAM_ORDER-1:0]      data_sym;
    logic [PAM_ORDER-1:0]      data_k;
    logic                      unused_tkeep;

    assign unused_tkeep = ^s_axi_tkeep;
    assign data_sym     = shift_q[WIDTH_AXI_DATA-1 -: PAM_ORDER];
`ifdef PAM_GRAY_EN
    assign data_k = gray2bin(data_sym);
`else
    assign data_k = data_sym;
`endif

    // A reload is due on the last pilot and at each slot boundary except after the final symbol.
    always_comb begin
        load_shift = 1'b0;
        if (state_q == StPilot && sym_cnt_q == LastPilot) begin
            load_shift = 1'b1;
        end
        if (state_q == StData && slot_cnt_q == LastSlot && sym_cnt_q != LastSym) begin
            load_shift = 1'b1;
        end
    end

    assign hold_unload  = load_shift & hold_full_q;
    assign s_axi_tready = rst_n & (~hold_full_q | hold_unload);
    assign accept       = s_axi_tvalid & s_axi_tready;

    always_comb begin
        state_d        = state_q;
        sym_cnt_d      = sym_cnt_q;
        slot_cnt_d     = slot_cnt_q;
        word_cnt_d     = word_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        hold_last_d    = hold_last_q;
        shift_d        = shift_q;
        slot_empty_d   = slot_empty_q;
        valid_d        = 1'b0;
        data_d         = '0;
        sof_d          = 1'b0;
        eof_d          = 1'b0;
        err_underrun_d = err_underrun_q;
        err_framing_d  = err_framing_q;

        if (accept) begin
            hold_d      = s_axi_tdata;
            hold_last_d = s_axi_tlast;
            hold_full_d = 1'b1;
        end else if (hold_unload) begin
            hold_full_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    state_d    = StPilot;
                    sym_cnt_d  = CntW'(1);
                    word_cnt_d = '0;
                    valid_d    = 1'b1;
                    sof_d      = 1'b1;
                    data_d     = level_of(PAM_ORDER'(0));
                end
            end
            StPilot: begin
                valid_d = 1'b1;
                data_d  = level_of(sym_cnt_q[PAM_ORDER-1:0]);
                if (sym_cnt_q == LastPilot) begin
                    state_d   = StData;
                    sym_cnt_d = '0;
                end else begin
                    sym_cnt_d = sym_cnt_q + CntW'(1);
                end
            end
            StData: begin
                valid_d    = 1'b1;
                data_d     = slot_empty_q ? '0 : level_of(data_k);
                shift_d    = shift_q << PAM_ORDER;
                slot_cnt_d = slot_cnt_q + SlotW'(1);
                sym_cnt_d  = sym_cnt_q + CntW'(1);
                if (sym_cnt_q == LastSym) begin
                    eof_d     = 1'b1;
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end
            end
            default: begin
                if (gap_cnt_q == LastGap) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
        endcase

        // An empty hold at reload time leaves a silent slot; the frame timing is not stretched.
        if (load_shift) begin
            slot_cnt_d = '0;
            word_cnt_d = word_cnt_q + WordW'(1);
            if (hold_full_q) begin
                shift_d      = hold_q;
                slot_empty_d = 1'b0;
                if (hold_last_q != (word_cnt_q == LastWord)) begin
                    err_framing_d = 1'b1;
                end
            end else begin
                shift_d        = '0;
                slot_empty_d   = 1'b1;
                err_underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            sym_cnt_q      <= '0;
            slot_cnt_q     <= '0;
            word_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            hold_last_q    <= 1'b0;
            shift_q        <= '0;
            slot_empty_q   <= 1'b0;
            valid_q        <= 1'b0;
            data_q         <= '0;
            sof_q          <= 1'b0;
            eof_q          <= 1'b0;
            err_underrun_q <= 1'b0;
            err_framing_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sym_cnt_q      <= sym_cnt_d;
            slot_cnt_q     <= slot_cnt_d;
            word_cnt_q     <= word_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            hold_last_q    <= hold_last_d;
            shift_q        <= shift_d;
            slot_empty_q   <= slot_empty_d;
            valid_q        <= valid_d;
            data_q         <= data_d;
            sof_q          <= sof_d;
            eof_q          <= eof_d;
            err_underrun_q <= err_underrun_d;
            err_framing_q  <= err_framing_d;
        end
    end

    assign mod_da_valid = valid_q;
    assign mod_da_data  = data_q;
    assign mod_da_sof   = sof_q;
    assign mod_da_eof   = eof_q;
    assign err_underrun = err_underrun_q;
    assign err_framing  = err_framing_q;

endmodule

// File: tb/tb_pam_modulation.sv
// Bench for pam_modulation: directed frame scenarios with random payload words, checked against a
// sample-level frame model built from the accepted word list.
module tb_pam_modulation;

    localparam int AD   = 12;
    localparam int P    = 4;
    localparam int W    = 32;
    localparam int LD   = 1024;
    localparam int G    = 16;
    localparam int NL   = 1 << P;
    localparam int SPW  = W / P;
    localparam int WPF  = LD / SPW;
    localparam int FLEN = NL + LD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_axi_tvalid;
    logic          s_axi_tready;
    logic [W-1:0]  s_axi_tdata;
    logic [W/8-1:0] s_axi_tkeep;
    logic          s_axi_tlast;
    logic          mod_da_valid;
    logic [AD-1:0] mod_da_data;
    logic          mod_da_sof;
    logic          mod_da_eof;
    logic          err_underrun;
    logic          err_framing;

    always #5 clk = ~clk;

    pam_modulation #(
        .AD_CVER_WIDTH (AD),
        .LENGTH_DATA   (LD),
        .PAM_ORDER     (P),
        .WIDTH_AXI_DATA(W),
        .GUARD_LEN     (G)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axi_tvalid(s_axi_tvalid),
        .s_axi_tready(s_axi_tready),
        .s_axi_tdata (s_axi_tdata),
        .s_axi_tkeep (s_axi_tkeep),
        .s_axi_tlast (s_axi_tlast),
        .mod_da_valid(mod_da_valid),
        .mod_da_data (mod_da_data),
        .mod_da_sof  (mod_da_sof),
        .mod_da_eof  (mod_da_eof),
        .err_underrun(err_underrun),
        .err_framing (err_framing)
    );

    int checks = 0;
    int errors = 0;

    bit lv[$], lsof[$], leof[$], lun[$], lfr[$];
    int ld[$];
    int acc_log[$];

    logic [W-1:0] wq[$];
    bit           lq[$];
    int           widx, stall, stall_after, stall_len;

    logic [W-1:0] slot_w[$];
    bit           slot_ok[$];
    int           exp_q[$];

    task automatic chk(input string tag, input integer obs, input integer expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int sym_level(input int d);
        int k = d;
`ifdef PAM_GRAY_EN
        for (int s = 1; s < P; s++) k = k ^ (d >> s);
`endif
        return (k - NL / 2) * (1 << (AD - P));
    endfunction

    task automatic build_exp();
        exp_q.delete();
        for (int k = 0; k < NL; k++) exp_q.push_back((k - NL / 2) * (1 << (AD - P)));
        for (int s = 0; s < slot_w.size(); s++) begin
            for (int j = 0; j < SPW; j++) begin
                int d;
                d = int'((slot_w[s] >> (W - P * (j + 1))) & ((1 << P) - 1));
                exp_q.push_back(slot_ok[s] ? sym_level(d) : 0);
            end
        end
    endtask

    task automatic set_slots(input int first, input int n);
        slot_w.delete();
        slot_ok.delete();
        for (int i = 0; i < n; i++) begin
            slot_w.push_back(wq[first+i]);
            slot_ok.push_back(1'b1);
        end
    endtask

    task automatic drive();
        if (widx < wq.size() && stall == 0) begin
            s_axi_tvalid = 1'b1;
            s_axi_tdata  = wq[widx];
            s_axi_tlast  = lq[widx];
        end else begin
            s_axi_tvalid = 1'b0;
            s_axi_tdata  = '0;
            s_axi_tlast  = 1'b0;
        end
    endtask

    task automatic reset_drv();
        wq.delete();
        lq.delete();
        widx        = 0;
        stall       = 0;
        stall_after = -1;
        stall_len   = 0;
        drive();
    endtask

    task automatic clear_log();
        lv.delete(); lsof.delete(); leof.delete(); lun.delete(); lfr.delete();
        ld.delete(); acc_log.delete();
    endtask

    task automatic add_words(input int n, input bit rnd, input logic [W-1:0] base,
                             input int last_pos);
        for (int i = 0; i < n; i++) begin
            wq.push_back(rnd ? W'($urandom()) : base + W'(i));
            lq.push_back(i == last_pos);
        end
    endtask

    // One clock: handshake seen before the edge, outputs logged 1 time unit after it.
    task automatic tick();
        bit hs;
        @(negedge clk);
        hs = s_axi_tvalid && s_axi_tready;
        @(posedge clk);
        #1;
        lv.push_back(mod_da_valid);
        ld.push_back(int'($signed(mod_da_data)));
        lsof.push_back(mod_da_sof);
        leof.push_back(mod_da_eof);
        lun.push_back(err_underrun);
        lfr.push_back(err_framing);
        if (hs) begin
            acc_log.push_back(ld.size() - 1);
            if (widx == stall_after) stall = stall_len;
            widx++;
        end else if (stall > 0) begin
            stall--;
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_drv();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic int find_sof(input int from);
        for (int i = from; i < lsof.size(); i++) if (lsof[i]) return i;
        return -1;
    endfunction

    function automatic int find_eof(input int from);
        for (int i = from; i < leof.size(); i++) if (leof[i]) return i;
        return -1;
    endfunction

    task automatic check_frame(input int sof, input string name);
        int nval, nfirst, neof, nsof, gap_abs;
        chk({name, "_window"}, (sof >= 0 && sof + FLEN + G <= ld.size()) ? 1 : 0, 1);
        if (sof < 0 || sof + FLEN + G > ld.size()) return;
        nval = 0; nfirst = 0; neof = 0; nsof = 0; gap_abs = 0;
        for (int i = 0; i < FLEN + G; i++) begin
            nval += int'(lv[sof+i]);
            neof += int'(leof[sof+i]);
            nsof += int'(lsof[sof+i]);
            if (i < FLEN) nfirst += int'(lv[sof+i]);
            else gap_abs += (ld[sof+i] < 0) ? -ld[sof+i] : ld[sof+i];
        end
        chk({name, "_valid_total"}, nval, FLEN);
        chk({name, "_valid_contig"}, nfirst, FLEN);
        chk({name, "_eof_pos"}, int'(leof[sof+FLEN-1]), 1);
        chk({name, "_eof_count"}, neof, 1);
        chk({name, "_sof_count"}, nsof, 1);
        chk({name, "_valid_after_eof"}, int'(lv[sof+FLEN]), 0);
        chk({name, "_gap_data"}, gap_abs, 0);
        build_exp();
        for (int i = 0; i < FLEN; i++) begin
            chk($sformatf("%s_sample%0d", name, i), ld[sof+i], exp_q[i]);
        end
    endtask

    initial begin
        int sof, sof2, eof1, budget;

        s_axi_tkeep = '1;
        rst_n = 1'b0;
        reset_drv();
        #1;
        chk("tready_in_reset", s_axi_tready, 0);
        tick(); tick(); tick();
        chk("rst_valid", mod_da_valid, 0);
        chk("rst_data", mod_da_data, 0);
        chk("rst_sof", mod_da_sof, 0);
        chk("rst_eof", mod_da_eof, 0);
        chk("rst_err_underrun", err_underrun, 0);
        chk("rst_err_framing", err_framing, 0);
        chk("rst_tready_held", s_axi_tready, 0);
        rst_n = 1'b1;
        #1;
        chk("tready_after_release", s_axi_tready, 1);

        // Single frame with the reference word pattern.
        clear_log();
        add_words(WPF, 1'b0, 32'h0123_4567, WPF - 1);
        drive();
        repeat (1200) tick();
        sof = find_sof(0);
        chk("a_accepted", (acc_log.size() > 0) ? 1 : 0, 1);
        if (acc_log.size() > 0) chk("a_sof_latency", sof, acc_log[0] + 1);
        set_slots(0, WPF);
        check_frame(sof, "a");
        chk("a_err_underrun", err_underrun, 0);
        chk("a_err_framing", err_framing, 0);

        // Back-to-back frames, tvalid always offered.
        clear_log();
        reset_drv();
        add_words(WPF, 1'b1, '0, WPF - 1);
        add_words(WPF, 1'b1, '0, WPF - 1);
        drive();
        repeat (2300) tick();
        sof  = find_sof(0);
        eof1 = find_eof((sof >= 0) ? sof : 0);
        sof2 = find_sof(sof + 1);
        chk("b_sof_after_eof", sof2 - eof1, G + 1);
        set_slots(0, WPF);
        check_frame(sof, "b1");
        set_slots(WPF, WPF);
        check_frame(sof2, "b2");
        chk("b_err_underrun", err_underrun, 0);
        chk("b_err_framing", err_framing, 0);

        // Underrun: source stalls 20 cycles after word 5, so slot 6 goes silent.
        do_reset();
        clear_log();
        reset_drv();
        add_words(WPF, 1'b1, '0, WPF - 1);
        stall_after = 5;
        stall_len   = 20;
        drive();
        repeat (1200) tick();
        sof = find_sof(0);
        slot_w.delete();
        slot_ok.delete();
        for (int s = 0; s < WPF; s++) begin
            slot_w.push_back((s < 6) ? wq[s] : (s == 6) ? '0 : wq[s-1]);
            slot_ok.push_back(s != 6);
        end
        check_frame(sof, "c");
        if (sof >= 0 && sof + 64 < lun.size()) begin
            chk("c_underrun_before_slot6", int'(lun[sof+62]), 0);
            chk("c_underrun_at_slot6", int'(lun[sof+63]), 1);
        end
        chk("c_err_underrun_sticky", err_underrun, 1);

        // Framing: tlast on word 63.
        do_reset();
        clear_log();
        reset_drv();
        add_words(WPF, 1'b1, '0, 63);
        drive();
        repeat (1200) tick();
        sof = find_sof(0);
        chk("d_window", (sof >= 0 && sof + 520 < lfr.size()) ? 1 : 0, 1);
        if (sof >= 0 && sof + 520 < lfr.size()) begin
            chk("d_framing_before_word63", int'(lfr[sof+518]), 0);
            chk("d_framing_at_word63", int'(lfr[sof+519]), 1);
        end
        set_slots(0, WPF);
        check_frame(sof, "d");
        chk("d_err_underrun", err_underrun, 0);

        // Reset mid-DATA at symbol 300 of a frame that already flagged a framing error.
        do_reset();
        clear_log();
        reset_drv();
        add_words(WPF, 1'b1, '0, 10);
        drive();
        sof = -1;
        budget = 0;
        while (budget < 600 && (sof < 0 || ld.size() - 1 < sof + NL + 300)) begin
            tick();
            budget++;
            if (sof < 0) sof = find_sof(0);
        end
        chk("e_reached_sym300", (sof >= 0 && ld.size() - 1 == sof + NL + 300) ? 1 : 0, 1);
        chk("e_framing_before_reset", int'(lfr[lfr.size()-1]), 1);
        chk("e_valid_before_reset", int'(lv[lv.size()-1]), 1);
        rst_n = 1'b0;
        reset_drv();
        #1;
        chk("e_tready_rst_low", s_axi_tready, 0);
        tick();
        chk("e_rst_valid", mod_da_valid, 0);
        chk("e_rst_data", mod_da_data, 0);
        chk("e_rst_sof", mod_da_sof, 0);
        chk("e_rst_eof", mod_da_eof, 0);
        chk("e_rst_err_underrun", err_underrun, 0);
        chk("e_rst_err_framing", err_framing, 0);
        chk("e_rst_tready", s_axi_tready, 0);
        rst_n = 1'b1;
        #1;
        chk("e_tready_release", s_axi_tready, 1);

        clear_log();
        wq.push_back(32'h3333_3333);
        lq.push_back(1'b0);
        add_words(WPF - 1, 1'b1, '0, WPF - 2);
        drive();
        repeat (1200) tick();
        sof = find_sof(0);
        chk("e_accepted", (acc_log.size() > 0) ? 1 : 0, 1);
        if (acc_log.size() > 0) chk("e_sof_latency", sof, acc_log[0] + 1);
        set_slots(0, WPF);
        check_frame(sof, "e");
        if (sof >= 0 && sof + NL < ld.size()) begin
`ifdef PAM_GRAY_EN
            chk("e_first_data_level", ld[sof+NL], -1536);
`else
            chk("e_first_data_level", ld[sof+NL], -1280);
`endif
        end
        chk("e_err_underrun", err_underrun, 0);
        chk("e_err_framing", err_framing, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
